wired_tlb_update_ctrl: RTL

// - Write side of the TLB CAM. Turns TLBWR / TLBFILL / INVTLB commands from the CSR/exec pipe into
//   per-entry update strobes plus a broadcast key for the wired_tlb_match_single entries.
// - Keeps a shadow copy of every entry key, so INVTLB can evaluate its predicate while sweeping all

---
 rtl/wired0_defines.sv | 26 ++
 rtl/wired_tlb_inv_pred.sv | 33 +++
 rtl/wired_tlb_update_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/wired0_defines.sv
// Shared TLB definitions: command encodings, INVTLB op codes and the CAM entry key.
package wired0_defines;

  typedef enum logic [1:0] {
    TLB_CMD_WR   = 2'd0,
    TLB_CMD_FILL = 2'd1,
    TLB_CMD_INV  = 2'd2
  } tlb_cmd_e;

  localparam logic [4:0] INV_OP_ALL0         = 5'd0;
  localparam logic [4:0] INV_OP_ALL1         = 5'd1;
  localparam logic [4:0] INV_OP_G1           = 5'd2;
  localparam logic [4:0] INV_OP_G0           = 5'd3;
  localparam logic [4:0] INV_OP_G0_ASID      = 5'd4;
  localparam logic [4:0] INV_OP_G0_ASID_VA   = 5'd5;
  localparam logic [4:0] INV_OP_G_OR_ASID_VA = 5'd6;

  typedef struct packed {
    logic [18:0] vppn;
    logic [9:0]  asid;
    logic        g;
    logic        huge_page;
    logic        e;
  } tlb_key_t;

endpackage

// File: rtl/wired_tlb_inv_pred.sv
// INVTLB predicate for one shadow entry; only valid (e=1) entries can hit.
module wired_tlb_inv_pred
  import wired0_defines::*;
(
  input  tlb_key_t    key,
  input  logic [4:0]  inv_op,
  input  logic [9:0]  inv_asid,
  input  logic [18:0] inv_vppn,
  output logic        hit
);

  logic vm;
  logic am;
  logic sel;

  always_comb begin
    vm = (key.vppn[18:10] == inv_vppn[18:10]) &&
         (key.huge_page || (key.vppn[9:0] == inv_vppn[9:0]));
    am = (key.asid == inv_asid);
    sel = 1'b0;
    case (inv_op)
      INV_OP_ALL0, INV_OP_ALL1: sel = 1'b1;
      INV_OP_G1:                sel = key.g;
      INV_OP_G0:                sel = !key.g;
      INV_OP_G0_ASID:           sel = !key.g && am;
      INV_OP_G0_ASID_VA:        sel = !key.g && am && vm;
      INV_OP_G_OR_ASID_VA:      sel = (key.g || am) && vm;
      default:                  sel = 1'b0;
    endcase
    hit = sel && key.e;
  end

endmodule

// File: rtl/wired_tlb_update_ctrl.sv
// TLB CAM write side: turns TLBWR/TLBFILL/INVTLB into per-entry update strobes,
// keeping a shadow key array so INVTLB can sweep all entries one per slot.
module wired_tlb_update_ctrl
  import wired0_defines::*;
#(
  parameter int unsigned ENTRIES    = 32,
  parameter bit          ENABLE_OPT = 1'b0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  tlb_cmd_e                   cmd_op_i,
  input  logic [$clog2(ENTRIES)-1:0] idx_i,
  input  tlb_key_t                   key_i,
  input  logic [4:0]                 inv_op_i,
  input  logic [9:0]                 inv_asid_i,
  input  logic [18:0]                inv_vppn_i,
  output logic [ENTRIES-1:0]         update_o,
  output tlb_key_t                   update_key_o,
  output logic [$clog2(ENTRIES)-1:0] fill_idx_o,
  output logic                       done_o
);

  localparam int unsigned IW = $clog2(ENTRIES);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_SWEEP, ST_DONE} state_e;

  state_e         state_q, state_d;
  tlb_key_t       shadow_q [ENTRIES];
  logic [15:0]    lfsr_q;
  logic           hold_q;
  logic           hold_last;
  logic [IW-1:0]  idx_q;
  logic [IW-1:0]  fill_idx_q;
  logic [IW-1:0]  sweep_q;
  tlb_key_t       key_q;
  tlb_key_t       sweep_key;
  logic [4:0]     inv_op_q;
  logic [9:0]     inv_asid_q;
  logic [18:0]    inv_vppn_q;
  logic           inv_hit;
  logic           accept;

  assign accept     = cmd_valid_i && cmd_ready_o;
  assign hold_last  = ENABLE_OPT ? hold_q : 1'b1;
  assign sweep_key  = shadow_q[sweep_q];
  assign fill_idx_o = fill_idx_q;

  wired_tlb_inv_pred u_pred (
    .key      (sweep_key),
    .inv_op   (inv_op_q),
    .inv_asid (inv_asid_q),
    .inv_vppn (inv_vppn_q),
    .hit      (inv_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    cmd_ready_o  = 1'b0;
    done_o       = 1'b0;
    update_o     = '0;
    update_key_o = '0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_d = (cmd_op_i == TLB_CMD_INV) ? ST_SWEEP : ST_WRITE;
      end
      ST_WRITE: begin
        update_o[idx_q] = 1'b1;
        update_key_o    = key_q;
        if (hold_last) state_d = ST_DONE;
      end
      ST_SWEEP: begin
        if (inv_hit) begin
          update_o[sweep_q] = 1'b1;
          update_key_o      = sweep_key;
          update_key_o.e    = 1'b0;
        end
        // all-ones sweep index is entry E-1 since E is a power of two
        if (hold_last && (&sweep_q)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q     <= LFSR_SEED;
      hold_q     <= 1'b0;
      idx_q      <= '0;
      fill_idx_q <= '0;
      sweep_q    <= '0;
      key_q      <= '0;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_vppn_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) shadow_q[i] <= '0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      if (accept) begin
        hold_q     <= 1'b0;
        sweep_q    <= '0;
        key_q      <= key_i;
        inv_op_q   <= inv_op_i;
        inv_asid_q <= inv_asid_i;
        inv_vppn_q <= inv_vppn_i;
        if (cmd_op_i == TLB_CMD_FILL) begin
          idx_q      <= lfsr_q[IW-1:0];
          fill_idx_q <= lfsr_q[IW-1:0];
        end else begin
          idx_q <= idx_i;
        end
      end
      if (state_q == ST_WRITE || state_q == ST_SWEEP) hold_q <= ENABLE_OPT ? ~hold_q : 1'b0;
      if (state_q == ST_WRITE && !hold_q) shadow_q[idx_q] <= key_q;
      // e is cleared only on the last hold slot so the entry keeps hitting while its strobe is held
      if (state_q == ST_SWEEP && hold_last) begin
        if (inv_hit) shadow_q[sweep_q].e <= 1'b0;
        sweep_q <= sweep_q + 1'b1;
      end
    end
  end

endmodule
